// File: rtl/spi_byte_slave.sv
// spi_byte_slave: SPI mode-0 (CPOL=0, CPHA=0) byte slave, oversampled in the clk domain.
//   Parameters: SYNC_STAGES  synchronizer depth per SPI input (>= 2)
//               IDLE_MISO    level driven on spi_miso while deselected
//   Ports:      clk, reset           system clock, synchronous active-high reset
//               spi_sck/cs_n/mosi    asynchronous SPI pins from the MCU
//               spi_miso, _oe        slave-out data and pad output enable
//               rd_data, rd_valid    received byte and its one-cycle strobe
//               wr_data, wr_valid    next transmit byte and its one-cycle request
//               start                one-cycle pulse at each transaction start
// Maximum SCK rate is clk / (2*(SYNC_STAGES+2)).
module spi_byte_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_MISO   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       start
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 3;
  localparam logic [BYTE_W-1:0] TX_FIRST = 8'h00;
  localparam logic [CNT_W-1:0]  CNT_LAST = 3'd7;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  // Synchronizers, delayed copies for edge detection, post-reset qualification
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic [SYNC_STAGES:0]   r_flush;
  logic                   r_armed;

  // Datapath registers
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_rx;
  logic [BYTE_W-1:0] r_tx;
  logic [BYTE_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_wr_valid;
  logic              r_start;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_any_rise;

  logic              w_sck;
  logic              w_cs_n;
  logic              w_mosi;
  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic              w_active;
  logic [BYTE_W-1:0] w_rx_next;

  // Input synchronizers; flops reset to idle pin levels
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= {SYNC_STAGES{1'b0}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush     <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs_n;
      r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      // Only arm once real pin data shows CS_n high, so a transaction already
      // in progress when reset releases is ignored until the next CS_n fall.
      r_armed     <= r_armed | (r_flush[SYNC_STAGES] & w_cs_n & r_cs_d);
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = r_armed & r_cs_d & ~w_cs_n;
  assign w_cs_rise  = r_armed & ~r_cs_d & w_cs_n;
  // Selected in this and the previous cycle: SCK edges coincident with a CS
  // edge are dropped because CS handling takes priority.
  assign w_active   = r_armed & ~r_cs_d & ~w_cs_n;
  assign w_rx_next  = {r_rx[BYTE_W-2:0], w_mosi};

  // Shift engine and output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_start    <= 1'b0;
      r_miso     <= IDLE_MISO;
      r_miso_oe  <= 1'b0;
      r_any_rise <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      if (w_cs_fall) begin
        r_start    <= 1'b1;
        r_bit_cnt  <= '0;
        r_rx       <= '0;
        r_tx       <= TX_FIRST;
        r_miso     <= TX_FIRST[BYTE_W-1];
        r_miso_oe  <= 1'b1;
        r_any_rise <= 1'b0;
      end else if (w_cs_rise) begin
        r_bit_cnt  <= '0;
        r_miso     <= IDLE_MISO;
        r_miso_oe  <= 1'b0;
      end else if (w_active) begin
        if (w_sck_rise) begin
          r_rx       <= w_rx_next;
          r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          r_any_rise <= 1'b1;
          if (r_bit_cnt == CNT_LAST) begin
            r_rd_data  <= w_rx_next;
            r_rd_valid <= 1'b1;
            r_wr_valid <= 1'b1;
          end
        end else if (w_sck_fall) begin
          if (r_bit_cnt == '0) begin
            // Byte boundary; a fall before the first rise keeps the 0x00 byte
            if (r_any_rise) begin
              r_tx   <= wr_data;
              r_miso <= wr_data[BYTE_W-1];
            end
          end else begin
            r_tx   <= {r_tx[BYTE_W-2:0], 1'b0};
            r_miso <= r_tx[BYTE_W-2];
          end
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign wr_valid    = r_wr_valid;
  assign start       = r_start;

endmodule

// File: tb/tb_spi_byte_slave.sv
// tb_spi_byte_slave: SPI master driver plus byte-level reference model for spi_byte_slave.
module tb_spi_byte_slave;

  localparam int unsigned HALF      = 4;     // clk cycles per SCK half period (clk/8)
  localparam logic        IDLE_MISO = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       start;

  always #5 clk = ~clk;

  spi_byte_slave #(.SYNC_STAGES(2), .IDLE_MISO(IDLE_MISO)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .start       (start)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int n_start = 0;
  int n_rd   = 0;
  int n_wr   = 0;
  int n_viol = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_start = 1'b0;

  logic [7:0] obs_rd[$];   // bytes seen on rd_data at rd_valid
  logic [7:0] sup_q[$];    // bytes supplied on wr_data in the current transaction
  logic [7:0] plan_q[$];   // preset wr_data responses, random once empty
  logic [7:0] mosi_q[$];   // bytes the master sends in the next transaction
  logic [7:0] last_rd = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor
  always @(negedge clk) begin
    if (start) n_start <= n_start + 1;
    if (wr_valid) n_wr <= n_wr + 1;
    if (rd_valid) begin
      n_rd <= n_rd + 1;
      obs_rd.push_back(rd_data);
    end
    if ((start && prev_start) || (rd_valid && prev_rd) || (wr_valid && prev_wr))
      n_viol <= n_viol + 1;
    prev_start <= start;
    prev_rd    <= rd_valid;
    prev_wr    <= wr_valid;
  end

  // Consumer: present the next byte one cycle after each wr_valid
  initial begin : responder
    logic [7:0] v;
    wr_data = 8'h00;
    forever begin
      @(negedge clk);
      if (wr_valid === 1'b1) begin
        @(negedge clk);
        v = (plan_q.size() > 0) ? plan_q.pop_front() : 8'($urandom);
        wr_data = v;
        sup_q.push_back(v);
      end
    end
  end

  // One SCK period: MOSI set on the falling edge, MISO sampled at the rising edge
  task automatic sck_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  // Full transaction of mosi_q bytes plus abort_bits trailing bits, checked against the model
  task automatic run_txn(input int abort_bits);
    logic [7:0]  mb;
    logic        m;
    logic [31:0] exp;
    int s0, w0, n;
    n  = mosi_q.size();
    sup_q.delete();
    obs_rd.delete();
    s0 = n_start;
    w0 = n_wr;
    spi_cs_n = 1'b0;
    repeat (2*HALF) @(negedge clk);
    check_val("start_pulse", 32'(n_start - s0), 1);
    check_val("oe_active", spi_miso_oe, 1);
    check_val("miso_first_bit", spi_miso, 0);
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        sck_bit(mosi_q[k][i], m);
        mb[i] = m;
      end
      if (k == 0) exp = 32'h0;
      else if (sup_q.size() >= k) exp = 32'(sup_q[k-1]);
      else exp = 32'h100;
      check_val("miso_byte", mb, exp);
    end
    for (int j = 0; j < abort_bits; j++) sck_bit(1'($urandom_range(0, 1)), m);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
    check_val("rd_count", obs_rd.size(), n);
    for (int k = 0; k < n && k < obs_rd.size(); k++)
      check_val("rd_byte", obs_rd[k], mosi_q[k]);
    check_val("wr_count", 32'(n_wr - w0), n);
    if (n > 0) last_rd = mosi_q[n-1];
    check_val("rd_data_hold", rd_data, last_rd);
    check_val("oe_idle", spi_miso_oe, 0);
    check_val("miso_idle", spi_miso, IDLE_MISO);
  endtask

  initial begin : main
    logic m;
    int s0, w0, r0;
    reset = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_rd_valid", rd_valid, 0);
    check_val("rst_wr_valid", wr_valid, 0);
    check_val("rst_start", start, 0);
    check_val("rst_miso", spi_miso, IDLE_MISO);
    check_val("rst_oe", spi_miso_oe, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Single byte
    mosi_q = {8'hA5};
    run_txn(0);

    // Loopback with preset responses
    mosi_q = {8'h03, 8'h00, 8'h00, 8'h01};
    plan_q = {8'h3C, 8'h5A, 8'hFF};
    run_txn(0);

    // Abort after 5 bits, then a clean byte
    mosi_q.delete();
    run_txn(5);
    mosi_q = {8'h81};
    run_txn(0);

    // Sixteen-byte stream at max rate
    mosi_q.delete();
    for (int k = 0; k < 16; k++) mosi_q.push_back(8'(k));
    run_txn(0);

    // Reset in the middle of a byte with CS_n held low
    obs_rd.delete();
    s0 = n_start;
    w0 = n_wr;
    spi_cs_n = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int j = 0; j < 3; j++) sck_bit(1'($urandom_range(0, 1)), m);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mid_rst_rd_data", rd_data, 0);
    check_val("mid_rst_rd_valid", rd_valid, 0);
    check_val("mid_rst_wr_valid", wr_valid, 0);
    check_val("mid_rst_start", start, 0);
    check_val("mid_rst_miso", spi_miso, IDLE_MISO);
    check_val("mid_rst_oe", spi_miso_oe, 0);
    reset = 1'b0;
    last_rd = 8'h00;
    for (int j = 0; j < 13; j++) sck_bit(1'($urandom_range(0, 1)), m);
    check_val("post_rst_oe", spi_miso_oe, 0);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2*HALF) @(negedge clk);
    check_val("post_rst_rd_count", obs_rd.size(), 0);
    check_val("post_rst_wr_count", 32'(n_wr - w0), 0);
    check_val("post_rst_start", 32'(n_start - s0), 1);
    check_val("post_rst_rd_data", rd_data, 0);
    mosi_q = {8'hC3};
    run_txn(0);

    // SCK toggling while deselected
    s0 = n_start;
    w0 = n_wr;
    r0 = n_rd;
    repeat (10) begin
      spi_mosi = 1'($urandom_range(0, 1));
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    check_val("idle_start", 32'(n_start - s0), 0);
    check_val("idle_rd", 32'(n_rd - r0), 0);
    check_val("idle_wr", 32'(n_wr - w0), 0);
    check_val("idle_miso", spi_miso, IDLE_MISO);
    check_val("idle_oe", spi_miso_oe, 0);

    // Randomized transactions, some ending in a partial byte
    repeat (8) begin
      int nb;
      nb = $urandom_range(1, 4);
      mosi_q.delete();
      for (int k = 0; k < nb; k++) mosi_q.push_back(8'($urandom));
      run_txn(($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
    end

    check_val("pulse_width", n_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/spi_byte_slave.md
Name: spi_byte_slave

Overview:
SPI mode-0 slave that converts the MCU's serial link into the byte stream consumed by the command/API decoder. It oversamples SCK, CS_n and MOSI in the clk domain. It emits received bytes with a one-cycle rd_valid pulse and a start pulse at the beginning of each transaction. It requests transmit bytes with wr_valid and shifts them out on MISO.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (min 2)
IDLE_MISO, 1'b0, value driven on spi_miso while CS_n is high

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high; clock clk
spi_sck  in  1  SPI clock from MCU, asynchronous, CPOL=0
spi_cs_n  in  1  chip select, active low, asynchronous
spi_mosi  in  1  master-out data, asynchronous
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  MISO output enable (pad tri-state control)
rd_data  out  8  last received byte, MSB first on wire
rd_valid  out  1  one-cycle pulse: rd_data holds a new byte
wr_data  in  8  next byte to transmit, supplied by consumer
wr_valid  out  1  one-cycle pulse: consumer must present next wr_data
start  out  1  one-cycle pulse on synced CS_n falling edge

Behaviour:
- Reset values: rd_data=0, rd_valid=0, wr_valid=0, start=0, spi_miso=IDLE_MISO, spi_miso_oe=0, bit_cnt=0, tx shift=0. Synchronizer flops reset to idle levels: sck=0, cs_n=1, mosi=0.
- Synchronize sck, cs_n and mosi through SYNC_STAGES flops. Detect edges from the last synced stage against one extra registered copy.
- Timing requirement: f_SCK <= f_clk / (2*(SYNC_STAGES+2)), i.e. clk/8 at the default setting. Setup to the MCU's MISO sampling is not guaranteed above this rate.
- State is implicit in cs_n_sync: IDLE when high, ACTIVE when low.
- CS_n falling, IDLE->ACTIVE:
  - start=1 for exactly one cycle.
  - bit_cnt=0, rx shift cleared, tx shift loaded with 8'h00.
  - spi_miso_oe=1, spi_miso=tx[7].
  - The first (command) byte therefore returns 0x00.
- SCK rising while ACTIVE:
  - rx shift = {rx[6:0], mosi_sync}; bit_cnt increments and wraps 7->0.
  - When bit_cnt was 7: rd_data = completed byte, and rd_valid=1 and wr_valid=1 together for one cycle. The total is at most SYNC_STAGES+2 clk after the 8th pin-level rising edge.
- SCK falling while ACTIVE:
  - If bit_cnt==0 (byte boundary, not the first byte): tx shift loads wr_data, spi_miso = wr_data[7].
  - Otherwise: tx shift shifts left, spi_miso = next bit.
  - The consumer has at least the SCK low half-period minus sync latency (>=2 clk at max rate) between wr_valid and wr_data sampling. One registered-response cycle is required to fit.
  - A falling edge before any rising edge in a transaction does not reload.
- CS_n rising, ACTIVE->IDLE:
  - Partial byte discarded: no rd_valid, no wr_valid. bit_cnt=0, spi_miso_oe=0, spi_miso=IDLE_MISO.
  - rd_data keeps its last value.
- SCK edges while IDLE are ignored.
- A CS_n rising edge and an SCK edge in the same synced cycle: CS wins, the byte is not completed.
- A CS_n falling edge in the same cycle as an SCK rising edge: start is issued and that edge is ignored. The master must respect CS-to-SCK setup >= 2 clk.
- Back-to-back transactions: start re-asserts on each new CS_n fall regardless of prior byte state.
- reset mid-transaction: all state returns to reset values next cycle. A transaction continuing after reset release is ignored until the next CS_n falling edge.
- rd_valid, wr_valid and start are never high for more than one consecutive cycle.

Test Plan:
1. Single byte, clk=8×SCK: CS_n low, shift 0xA5, CS_n high -> start pulse once; rd_data=0xA5 with rd_valid and wr_valid high for one cycle; MISO bits all 0.
2. Loopback: 4-byte transfer 0x03,0x00,0x00,0x01; bench drives wr_data=0x3C, 0x5A, 0xFF one cycle after each wr_valid -> MISO bytes 0x00, 0x3C, 0x5A, 0xFF; four rd_valid pulses with the matching bytes.
3. Abort: CS_n rises after 5 SCK rising edges -> no rd_valid, spi_miso_oe=0. Next transaction sending 0x81 -> rd_data=0x81, bit alignment correct.
4. Max rate stream: 16 consecutive bytes 0x00..0x0F at f_SCK=clk/8 -> 16 rd_valid pulses in order, no missed or duplicate pulse.
5. reset asserted mid-byte (after 3 bits), released while CS_n is still low -> outputs at reset values, no rd_valid until CS_n toggles. A fresh transaction of 0xC3 is received correctly.
6. Idle SCK toggling with CS_n high (10 pulses) -> no start, rd_valid or wr_valid; spi_miso=IDLE_MISO, spi_miso_oe=0.
